// File: rtl/pic_pkg.sv
// Shared encodings for the PIC host interface: command-word flag codes,
// read-select codes and the ICW initialisation sequence states.
package pic_pkg;

    localparam logic [2:0] FLAG_ICW1 = 3'd0;
    localparam logic [2:0] FLAG_ICW2 = 3'd1;
    localparam logic [2:0] FLAG_ICW3 = 3'd2;
    localparam logic [2:0] FLAG_ICW4 = 3'd3;
    localparam logic [2:0] FLAG_OCW1 = 3'd4;
    localparam logic [2:0] FLAG_OCW2 = 3'd5;
    localparam logic [2:0] FLAG_OCW3 = 3'd6;
    localparam logic [2:0] FLAG_IDLE = 3'd7;

    localparam logic [2:0] RSEL_IRR  = 3'b001;
    localparam logic [2:0] RSEL_ISR  = 3'b101;
    localparam logic [2:0] RSEL_IMR  = 3'b011;
    localparam logic [2:0] RSEL_NONE = 3'b000;

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } seq_state_t;

    // ICW1 is recognised anywhere: even address with D4 set.
    function automatic logic is_icw1(input logic a0, input logic [7:0] data);
        return (a0 == 1'b0) && (data[4] == 1'b1);
    endfunction

endpackage

// File: rtl/rw_strobe_capture.sv
// Latches the CPU byte and address during a selected write strobe and
// raises commit in the cycle after the strobe's rising edge.
module rw_strobe_capture
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] data_in,
    output logic       commit,
    output logic       cmd_a0,
    output logic [7:0] cmd_data
);

    logic       wr_n_r;
    logic       pending_r;
    logic       a0_r;
    logic [7:0] data_r;

    // A strobe only commits if cs_n was low during at least one low cycle of wr_n.
    assign commit   = pending_r & ~wr_n_r & wr_n;
    assign cmd_a0   = a0_r;
    assign cmd_data = data_r;

    // Strobe history and write latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_n_r    <= 1'b1;
            pending_r <= 1'b0;
            a0_r      <= 1'b0;
            data_r    <= 8'h00;
        end else begin
            wr_n_r <= wr_n;
            if (!cs_n && !wr_n) begin
                data_r    <= data_in;
                a0_r      <= a0;
                pending_r <= 1'b1;
            end else if (commit) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

endmodule

// File: rtl/rw_command_sequencer.sv
// Host write/read front end of the PIC: turns committed bus writes into
// one-cycle command flags and drives the registered read-select path.
module rw_command_sequencer
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic       a0,
    input  logic [7:0] data_in,
    output logic [2:0] rw_flag,
    output logic [7:0] rw_data,
    output logic [2:0] read_sel,
    output logic       data_oe,
    output logic       init_done
);

    logic       commit_s;
    logic       cmd_a0_s;
    logic [7:0] cmd_data_s;

    seq_state_t state_r, state_nx_s;
    logic [2:0] flag_r, flag_nx_s;
    logic [7:0] data_r, data_nx_s;
    logic       sngl_r, sngl_nx_s;
    logic       ic4_r, ic4_nx_s;
    logic       ris_r, ris_nx_s;
    logic [2:0] rsel_r, rsel_nx_s;
    logic       oe_r, oe_nx_s;
    logic       init_done_r;
    logic       rd_hit_s;

    rw_strobe_capture u_capture (
        .clk      (clk),
        .reset    (reset),
        .cs_n     (cs_n),
        .wr_n     (wr_n),
        .a0       (a0),
        .data_in  (data_in),
        .commit   (commit_s),
        .cmd_a0   (cmd_a0_s),
        .cmd_data (cmd_data_s)
    );

    // Sequencer next-state and command decode.
    always_comb begin
        state_nx_s = state_r;
        flag_nx_s  = FLAG_IDLE;
        data_nx_s  = data_r;
        sngl_nx_s  = sngl_r;
        ic4_nx_s   = ic4_r;
        ris_nx_s   = ris_r;
        if (commit_s && is_icw1(cmd_a0_s, cmd_data_s)) begin
            flag_nx_s  = FLAG_ICW1;
            data_nx_s  = cmd_data_s;
            sngl_nx_s  = cmd_data_s[1];
            ic4_nx_s   = cmd_data_s[0];
            state_nx_s = WAIT_ICW2;
        end else if (commit_s && cmd_a0_s) begin
            case (state_r)
                WAIT_ICW2: begin
                    flag_nx_s = FLAG_ICW2;
                    data_nx_s = cmd_data_s;
                    if (!sngl_r) begin
                        state_nx_s = WAIT_ICW3;
                    end else if (ic4_r) begin
                        state_nx_s = WAIT_ICW4;
                    end else begin
                        state_nx_s = READY;
                    end
                end
                WAIT_ICW3: begin
                    flag_nx_s  = FLAG_ICW3;
                    data_nx_s  = cmd_data_s;
                    state_nx_s = ic4_r ? WAIT_ICW4 : READY;
                end
                WAIT_ICW4: begin
                    flag_nx_s  = FLAG_ICW4;
                    data_nx_s  = cmd_data_s;
                    state_nx_s = READY;
                end
                READY: begin
                    flag_nx_s = FLAG_OCW1;
                    data_nx_s = cmd_data_s;
                end
                default: state_nx_s = state_r;
            endcase
        end else if (commit_s && (state_r == READY)) begin
            // Even address without D4: D3 selects OCW2 versus OCW3.
            data_nx_s = cmd_data_s;
            if (cmd_data_s[3]) begin
                flag_nx_s = FLAG_OCW3;
                if (cmd_data_s[1]) begin
                    ris_nx_s = cmd_data_s[0];
                end else begin
                    ris_nx_s = ris_r;
                end
            end else begin
                flag_nx_s = FLAG_OCW2;
            end
        end else begin
            state_nx_s = state_r;
        end
    end

    // Read select decode; a concurrent write strobe suppresses the read.
    always_comb begin
        rd_hit_s  = !cs_n && !rd_n && wr_n && (state_r == READY);
        rsel_nx_s = RSEL_NONE;
        oe_nx_s   = 1'b0;
        if (rd_hit_s) begin
            oe_nx_s = 1'b1;
            if (a0) begin
                rsel_nx_s = RSEL_IMR;
            end else if (ris_r) begin
                rsel_nx_s = RSEL_ISR;
            end else begin
                rsel_nx_s = RSEL_IRR;
            end
        end else begin
            rsel_nx_s = RSEL_NONE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= UNINIT;
            flag_r      <= FLAG_IDLE;
            data_r      <= 8'h00;
            sngl_r      <= 1'b0;
            ic4_r       <= 1'b0;
            ris_r       <= 1'b0;
            rsel_r      <= RSEL_NONE;
            oe_r        <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            flag_r      <= flag_nx_s;
            data_r      <= data_nx_s;
            sngl_r      <= sngl_nx_s;
            ic4_r       <= ic4_nx_s;
            ris_r       <= ris_nx_s;
            rsel_r      <= rsel_nx_s;
            oe_r        <= oe_nx_s;
            init_done_r <= (state_nx_s == READY);
        end
    end

    assign rw_flag   = flag_r;
    assign rw_data   = data_r;
    assign read_sel  = rsel_r;
    assign data_oe   = oe_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_rw_command_sequencer.sv
// Directed self-checking bench for rw_command_sequencer: ICW sequences,
// OCW decode, read select, pre-init rejection, reset abort, read/write overlap.
module tb_rw_command_sequencer;

    logic       clk;
    logic       reset;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] data_in;
    logic [2:0] rw_flag;
    logic [7:0] rw_data;
    logic [2:0] read_sel;
    logic       data_oe;
    logic       init_done;

    int err_cnt;
    int chk_cnt;

    rw_command_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .wr_n      (wr_n),
        .rd_n      (rd_n),
        .a0        (a0),
        .data_in   (data_in),
        .rw_flag   (rw_flag),
        .rw_data   (rw_data),
        .read_sel  (read_sel),
        .data_oe   (data_oe),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
        end
    endtask

    // Entered and left at posedge+1: one low cycle, release, sample flag, sample idle.
    task automatic write_cmd(input logic a, input logic [7:0] d,
                             output logic [2:0] f, output logic [7:0] rd,
                             output logic [2:0] f_idle);
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; data_in = d;
        @(posedge clk); #1;
        wr_n = 1'b1; cs_n = 1'b1;
        @(posedge clk); #1;
        f  = rw_flag;
        rd = rw_data;
        @(posedge clk); #1;
        f_idle = rw_flag;
    endtask

    task automatic do_write(input string tag, input logic a, input logic [7:0] d,
                            input logic [2:0] exp_flag, input logic [7:0] exp_data);
        logic [2:0] f;
        logic [7:0] rd;
        logic [2:0] fi;
        write_cmd(a, d, f, rd, fi);
        check_eq({tag, "_flag"}, {5'd0, f}, {5'd0, exp_flag});
        check_eq({tag, "_data"}, rd, exp_data);
        check_eq({tag, "_idle"}, {5'd0, fi}, 8'h07);
    endtask

    task automatic do_read(input string tag, input logic a,
                           input logic [2:0] exp_sel, input logic exp_oe);
        cs_n = 1'b0; rd_n = 1'b0; a0 = a;
        @(posedge clk); #1;
        check_eq({tag, "_sel"}, {5'd0, read_sel}, {5'd0, exp_sel});
        check_eq({tag, "_oe"}, {7'd0, data_oe}, {7'd0, exp_oe});
        cs_n = 1'b1; rd_n = 1'b1;
        @(posedge clk); #1;
        check_eq({tag, "_sel_off"}, {5'd0, read_sel}, 8'h00);
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        reset = 1'b1; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a0 = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_flag", {5'd0, rw_flag}, 8'h07);
        check_eq("rst_data", rw_data, 8'h00);
        check_eq("rst_sel", {5'd0, read_sel}, 8'h00);
        check_eq("rst_oe", {7'd0, data_oe}, 8'h00);
        check_eq("rst_init", {7'd0, init_done}, 8'h00);

        // Writes before any ICW1 are dropped and leave rw_data alone.
        do_write("pre_ocw1", 1'b1, 8'hFF, 3'd7, 8'h00);
        do_write("pre_ocw2", 1'b0, 8'h20, 3'd7, 8'h00);
        do_read("pre_rd", 1'b0, 3'b000, 1'b0);
        check_eq("pre_init", {7'd0, init_done}, 8'h00);

        // Single mode with ICW4: ICW3 is skipped.
        do_write("s_icw1", 1'b0, 8'h13, 3'd0, 8'h13);
        check_eq("s_init1", {7'd0, init_done}, 8'h00);
        do_write("s_icw2", 1'b1, 8'h20, 3'd1, 8'h20);
        check_eq("s_init2", {7'd0, init_done}, 8'h00);
        do_write("s_icw4", 1'b1, 8'h01, 3'd3, 8'h01);
        check_eq("s_init4", {7'd0, init_done}, 8'h01);

        // Cascade without ICW4, including an ignored even write in WAIT_ICW2.
        do_write("c_icw1", 1'b0, 8'h10, 3'd0, 8'h10);
        check_eq("c_init1", {7'd0, init_done}, 8'h00);
        do_write("c_ign", 1'b0, 8'h08, 3'd7, 8'h10);
        do_write("c_icw2", 1'b1, 8'h08, 3'd1, 8'h08);
        do_write("c_icw3", 1'b1, 8'h04, 3'd2, 8'h04);
        check_eq("c_init3", {7'd0, init_done}, 8'h01);
        do_write("ocw1", 1'b1, 8'hFB, 3'd4, 8'hFB);

        // OCW2/OCW3 and read-register selection.
        do_read("rd_irr0", 1'b0, 3'b001, 1'b1);
        do_write("ocw2", 1'b0, 8'h20, 3'd5, 8'h20);
        do_write("ocw3_isr", 1'b0, 8'h0B, 3'd6, 8'h0B);
        do_read("rd_isr", 1'b0, 3'b101, 1'b1);
        do_read("rd_imr", 1'b1, 3'b011, 1'b1);
        do_write("ocw3_nrr", 1'b0, 8'h08, 3'd6, 8'h08);
        do_read("rd_isr2", 1'b0, 3'b101, 1'b1);
        do_write("ocw3_irr", 1'b0, 8'h0A, 3'd6, 8'h0A);
        do_read("rd_irr", 1'b0, 3'b001, 1'b1);

        // Read and write strobes together: the write wins.
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; data_in = 8'h55;
        @(posedge clk); #1;
        check_eq("ovl_oe", {7'd0, data_oe}, 8'h00);
        check_eq("ovl_sel", {5'd0, read_sel}, 8'h00);
        wr_n = 1'b1; rd_n = 1'b1; cs_n = 1'b1;
        @(posedge clk); #1;
        check_eq("ovl_flag", {5'd0, rw_flag}, 8'h04);
        check_eq("ovl_data", rw_data, 8'h55);
        @(posedge clk); #1;

        // Reset while waiting for ICW3 aborts the sequence.
        do_write("r_icw1", 1'b0, 8'h10, 3'd0, 8'h10);
        do_write("r_icw2", 1'b1, 8'h08, 3'd1, 8'h08);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("r_flag", {5'd0, rw_flag}, 8'h07);
        check_eq("r_init", {7'd0, init_done}, 8'h00);
        check_eq("r_data", rw_data, 8'h00);
        do_write("r_after", 1'b1, 8'h04, 3'd7, 8'h00);
        do_read("r_rd", 1'b1, 3'b000, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
